// File: rtl/axis_cc_fifo_pkg.sv
// Shared pointer helpers for the dual-clock AXI-Stream FIFO.
// Used by both the writer-side and reader-side controllers.
package axis_cc_fifo_pkg;

  localparam int unsigned ADDR_BITS_DEF = 5;
  localparam int unsigned PTR_BITS      = ADDR_BITS_DEF + 1;
  // Helpers work on a wide vector; callers zero-extend and truncate.
  localparam int unsigned GW            = 16;

  function automatic logic [GW-1:0] bin2gray(input logic [GW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] g);
    logic [GW-1:0] b;
    b[GW-1] = g[GW-1];
    for (int i = GW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/axis_rd_skid2.sv
// Two-entry registered output buffer (head + skid), strict FIFO order.
// Head drives the AXIS outputs directly so they stay registered.
module axis_rd_skid2 #(
  parameter int unsigned WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic [1:0]       cnt_o
);

  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] skid_q;
  logic             head_v_q;
  logic             skid_v_q;
  logic             pop;

  assign pop     = head_v_q && ready_i;
  assign data_o  = head_q;
  assign valid_o = head_v_q;
  assign cnt_o   = {1'b0, head_v_q} + {1'b0, skid_v_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q   <= '0;
      skid_q   <= '0;
      head_v_q <= 1'b0;
      skid_v_q <= 1'b0;
    end else if (pop) begin
      if (skid_v_q) begin
        head_q   <= skid_q;
        skid_v_q <= load_i;
        if (load_i) skid_q <= data_i;
      end else begin
        head_v_q <= load_i;
        if (load_i) head_q <= data_i;
      end
    end else if (load_i) begin
      // Issue control guarantees the skid is free here.
      if (!head_v_q) begin
        head_q   <= data_i;
        head_v_q <= 1'b1;
      end else begin
        skid_q   <= data_i;
        skid_v_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_cc_fifo_rd.sv
// Read-side controller of the dual-clock AXI-Stream FIFO.
// Issues RAM reads, prefetches into a 2-entry buffer, exports Gray read ptr.
module axis_cc_fifo_rd
  import axis_cc_fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = 12,
  parameter int unsigned ADDR_BITS = ADDR_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_BITS:0]   wr_ptr_gray_s,
  output logic [ADDR_BITS:0]   rd_ptr_gray,
  output logic                 ram_rd_en,
  output logic [ADDR_BITS-1:0] ram_raddr,
  input  logic [WIDTH-1:0]     ram_rdata,
  output logic [WIDTH-1:0]     m_tx_tdata,
  output logic                 m_tx_tvalid,
  input  logic                 m_tx_tready,
  output logic [ADDR_BITS:0]   fill_level
);

  localparam int unsigned PW = ADDR_BITS + 1;

  logic [PW-1:0] wr_bin_q;
  logic [PW-1:0] rd_bin_q;
  logic [PW-1:0] rd_bin_d;
  logic [PW-1:0] rd_gray_q;
  logic [PW-1:0] fill_q;
  logic          inflight_q;
  logic [1:0]    buf_cnt;
  logic          empty;
  logic          pop;
  logic [2:0]    occ;

  assign empty = (rd_bin_q == wr_bin_q);
  assign pop   = m_tx_tvalid && m_tx_tready;
  // Slots committed after this edge; never more than two.
  assign occ   = {1'b0, buf_cnt} + {2'b0, inflight_q} - {2'b0, pop};

  assign ram_rd_en   = !empty && (occ < 3'd2);
  assign ram_raddr   = rd_bin_q[ADDR_BITS-1:0];
  assign rd_bin_d    = rd_bin_q + PW'(ram_rd_en);
  assign rd_ptr_gray = rd_gray_q;
  assign fill_level  = fill_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bin_q   <= '0;
      rd_bin_q   <= '0;
      rd_gray_q  <= '0;
      inflight_q <= 1'b0;
      fill_q     <= '0;
    end else begin
      wr_bin_q   <= PW'(gray2bin(GW'(wr_ptr_gray_s)));
      rd_bin_q   <= rd_bin_d;
      rd_gray_q  <= PW'(bin2gray(GW'(rd_bin_d)));
      inflight_q <= ram_rd_en;
      fill_q     <= (wr_bin_q - rd_bin_q) + PW'(buf_cnt)
                  + PW'(inflight_q);
    end
  end

  axis_rd_skid2 #(
    .WIDTH(WIDTH)
  ) u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (inflight_q),
    .data_i (ram_rdata),
    .ready_i(m_tx_tready),
    .data_o (m_tx_tdata),
    .valid_o(m_tx_tvalid),
    .cnt_o  (buf_cnt)
  );

endmodule

// File: tb/tb_axis_cc_fifo_rd.sv
// Directed bench for axis_cc_fifo_rd with a RAM and writer model.
// Beat k carries dat(k); monitor checks order, AXIS hold and Gray steps.
module tb_axis_cc_fifo_rd;

  localparam int W  = 12;
  localparam int AB = 5;
  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [PW-1:0] wr_ptr_gray_s = '0;
  logic [PW-1:0] rd_ptr_gray;
  logic          ram_rd_en;
  logic [AB-1:0] ram_raddr;
  logic [W-1:0]  ram_rdata;
  logic [W-1:0]  m_tx_tdata;
  logic          m_tx_tvalid;
  logic          m_tx_tready = 1'b0;
  logic [PW-1:0] fill_level;

  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;
  int wr_target = 0;
  int exp_seq = 0;
  int rd_issues = 0;
  bit rand_rdy = 0;
  bit auto_wr = 0;
  bit prev_hold = 0;
  bit wrap_seen = 0;
  logic [W-1:0]  prev_data = '0;
  logic [PW-1:0] prev_gray = '0;
  logic [W-1:0]  mem [32];
  logic [W-1:0]  d0;

  axis_cc_fifo_rd #(
    .WIDTH(W),
    .ADDR_BITS(AB)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_ptr_gray_s(wr_ptr_gray_s),
    .rd_ptr_gray  (rd_ptr_gray),
    .ram_rd_en    (ram_rd_en),
    .ram_raddr    (ram_raddr),
    .ram_rdata    (ram_rdata),
    .m_tx_tdata   (m_tx_tdata),
    .m_tx_tvalid  (m_tx_tvalid),
    .m_tx_tready  (m_tx_tready),
    .fill_level   (fill_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_rd_en) ram_rdata <= mem[ram_raddr];
  end

  function automatic logic [W-1:0] dat(int k);
    return W'(k * 97 + 965);
  endfunction

  function automatic logic [PW-1:0] b2g(logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] g2b(logic [PW-1:0] g);
    logic [PW-1:0] b;
    for (int i = 0; i < PW; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_push(int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_cnt % 32] = dat(wr_cnt);
      wr_cnt++;
    end
    wr_ptr_gray_s = b2g(PW'(wr_cnt));
  endtask

  task automatic to_pos();
    int used;
    int n;
    @(posedge clk);
    #1;
    if (auto_wr && wr_cnt < wr_target) begin
      used = (wr_cnt - int'(g2b(rd_ptr_gray))) & 63;
      n = int'($urandom_range(0, 4));
      if (n > 32 - used) n = 32 - used;
      if (n > wr_target - wr_cnt) n = wr_target - wr_cnt;
      if (n > 0) wr_push(n);
    end
    if (rand_rdy) m_tx_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic to_neg();
    @(negedge clk);
    if (rst_n) begin
      if (ram_rd_en) rd_issues++;
      if (prev_hold) begin
        chk("hold_valid", 32'(m_tx_tvalid), 1);
        chk("hold_data", 32'(m_tx_tdata), 32'(prev_data));
      end
      if (m_tx_tvalid && m_tx_tready) begin
        chk("beat_data", 32'(m_tx_tdata), 32'(dat(exp_seq)));
        exp_seq++;
      end
      if (rd_ptr_gray != prev_gray) begin
        chk("gray_1bit", $countones(rd_ptr_gray ^ prev_gray), 1);
        if (prev_gray == 6'h20 && rd_ptr_gray == 6'h00) wrap_seen = 1;
        prev_gray = rd_ptr_gray;
      end
      prev_hold = m_tx_tvalid && !m_tx_tready;
      prev_data = m_tx_tdata;
    end
  endtask

  task automatic cyc(int n);
    repeat (n) begin
      to_pos();
      to_neg();
    end
  endtask

  task automatic wait_beats(int target, int budget);
    int k;
    k = 0;
    while (exp_seq < target && k < budget) begin
      cyc(1);
      k++;
    end
    chk("drain", exp_seq, target);
  endtask

  initial begin
    // Reset values, asserted without any clock edge
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(m_tx_tvalid), 0);
    chk("rst_gray", 32'(rd_ptr_gray), 0);
    chk("rst_fill", 32'(fill_level), 0);
    chk("rst_rden", 32'(ram_rd_en), 0);
    cyc(3);
    rst_n = 1'b1;

    // First-beat latency
    m_tx_tready = 1'b1;
    cyc(2);
    to_pos();
    wr_push(1);
    to_neg();
    chk("lat_rden_n", 32'(ram_rd_en), 0);
    cyc(1);
    chk("lat_rden_n1", 32'(ram_rd_en), 1);
    chk("lat_raddr", 32'(ram_raddr), 0);
    cyc(1);
    chk("lat_valid_n2", 32'(m_tx_tvalid), 0);
    chk("lat_gray", 32'(rd_ptr_gray), 1);
    cyc(1);
    chk("lat_valid_n3", 32'(m_tx_tvalid), 1);
    chk("lat_data", 32'(m_tx_tdata), 32'(dat(0)));
    chk("lat_seq", exp_seq, 1);

    // 32-entry burst, gapless stream
    to_pos();
    wr_push(32);
    to_neg();
    cyc(2);
    for (int i = 0; i < 32; i++) begin
      cyc(1);
      chk("gapless", 32'(m_tx_tvalid), 1);
    end
    chk("burst_seq", exp_seq, 33);
    cyc(3);
    chk("burst_fill", 32'(fill_level), 0);
    chk("burst_idle", 32'(m_tx_tvalid), 0);

    // Backpressure: two reads outstanding, then hold
    to_pos();
    m_tx_tready = 1'b0;
    rd_issues = 0;
    wr_push(10);
    to_neg();
    cyc(12);
    chk("bp_issues", rd_issues, 2);
    chk("bp_fill", 32'(fill_level), 10);
    chk("bp_valid", 32'(m_tx_tvalid), 1);
    d0 = m_tx_tdata;
    cyc(4);
    chk("bp_stable", 32'(m_tx_tdata), 32'(d0));
    chk("bp_head", 32'(m_tx_tdata), 32'(dat(33)));
    to_pos();
    m_tx_tready = 1'b1;
    to_neg();
    chk("bp_first_pop", exp_seq, 34);
    wait_beats(43, 40);
    cyc(3);
    chk("bp_fill_end", 32'(fill_level), 0);

    // Random ready over several pointer wraps
    rand_rdy = 1;
    auto_wr = 1;
    wr_target = wr_cnt + 150;
    wait_beats(wr_target, 3000);
    rand_rdy = 0;
    auto_wr = 0;
    chk("wrap_seen", 32'(wrap_seen), 1);
    chk("wrap_count", exp_seq, wr_cnt);

    // Reset with full local buffer
    to_pos();
    m_tx_tready = 1'b0;
    wr_push(10);
    to_neg();
    cyc(8);
    chk("pre_rst_valid", 32'(m_tx_tvalid), 1);
    chk("pre_rst_fill", 32'(fill_level), 10);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(m_tx_tvalid), 0);
    chk("mid_rst_gray", 32'(rd_ptr_gray), 0);
    chk("mid_rst_fill", 32'(fill_level), 0);
    wr_cnt = 0;
    exp_seq = 0;
    prev_hold = 0;
    prev_gray = '0;
    wr_ptr_gray_s = '0;
    cyc(2);
    rst_n = 1'b1;

    // Random ready with a bursty writer after reset
    rand_rdy = 1;
    auto_wr = 1;
    wr_target = 80;
    wait_beats(80, 2000);
    rand_rdy = 0;
    auto_wr = 0;
    chk("post_count", exp_seq, wr_cnt);
    to_pos();
    m_tx_tready = 1'b1;
    to_neg();
    cyc(3);
    chk("post_fill", 32'(fill_level), 0);
    chk("post_idle", 32'(m_tx_tvalid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
